ex_mdu: RTL and testbench

Multi-cycle integer multiply/divide unit for the execute stage, covering the RISC-V M-extension operations. It sits beside the single-cycle ALU and accepts operands through a valid/ready handshake. It iterates a shift-add or restoring-subtract datapath over several cycles, then presents the result through a second valid/ready handshake. The pipeline control uses `busy` / `in_ready` to stall issue while an operation is in flight.

---
 rtl/ex_mdu_pkg.sv | 34 +++
 rtl/mdu_step.sv | 39 +++
 rtl/ex_mdu.sv | 136 +++++++++++++
 tb/tb_ex_mdu.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared types for the multiply/divide unit: operation encodings, FSM states
// and small decode helpers used by the top level.
package ex_mdu_pkg;

  // Operation encodings follow the RISC-V M-extension funct3 field.
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  // rs1 is treated as signed for these operations.
  function automatic logic a_is_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as signed for these operations.
  function automatic logic b_is_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the multiply/divide datapath.
// The accumulator is {hi, lo}:
//   multiply: hi = partial product, lo = remaining multiplier bits (LSB first);
//   divide:   hi = partial remainder, lo = dividend bits shifting out / quotient
//             bits shifting in (MSB first).
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic                div_mode,
  input  logic [2*XLEN-1:0]   acc_in,
  input  logic [XLEN-1:0]     opnd,
  output logic [2*XLEN-1:0]   acc_out
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shl_rem;
  logic [XLEN:0]   sub_diff;

  assign hi       = acc_in[2*XLEN-1:XLEN];
  assign lo       = acc_in[XLEN-1:0];
  assign add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
  assign shl_rem  = {hi, lo[XLEN-1]};
  // The partial remainder stays below the divisor, so bit XLEN of the
  // difference is set only when the trial subtraction goes negative.
  assign sub_diff = shl_rem - {1'b0, opnd};

  // Select shift-add or restoring-subtract for this iteration.
  always_comb begin
    // NOTE: give every combinational output a default first so no path leaves it unassigned (which would infer a latch).
    acc_out = {add_sum, lo[XLEN-1:1]};
    if (div_mode) begin
      if (sub_diff[XLEN]) acc_out = {shl_rem[XLEN-1:0], lo[XLEN-2:0], 1'b0};
      else                acc_out = {sub_diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// Multi-cycle integer multiply/divide unit (RISC-V M extension).
// Operands are accepted in IDLE, iterated for XLEN/UNROLL cycles in CALC,
// sign-corrected in FIX and presented in DONE until the consumer takes them.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int S  = XLEN / UNROLL;
  localparam int CW = $clog2(S + 1);

  mdu_state_e        state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  md_op_e            op;
  logic              neg;

  md_op_e            in_op;
  logic              accept;
  logic              sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_val, div_signed, fix_res;
  logic [2*XLEN-1:0] chain [UNROLL+1];

  assign in_op  = md_op_e'(md_op);
  assign accept = in_valid && (state == MDU_IDLE) && !flush;

  // Operand magnitudes; the sign is reapplied in FIX.
  assign sa    = a_is_signed(in_op) && opA[XLEN-1];
  assign sb    = b_is_signed(in_op) && opB[XLEN-1];
  assign mag_a = sa ? -opA : opA;
  assign mag_b = sb ? -opB : opB;

  // Divide cases that bypass the iteration and finish straight from IDLE.
  assign div_zero = (opB == '0);
  assign div_ovf  = (opA == {1'b1, {(XLEN-1){1'b0}}}) && (opB == '1) &&
                    ((in_op == MD_DIV) || (in_op == MD_REM));
  assign special  = in_op[2] && (div_zero || div_ovf);

  // Result for the bypassed divide cases.
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = ((in_op == MD_DIV) || (in_op == MD_DIVU)) ? '1 : opA;
    else if (in_op == MD_DIV) special_res = opA;
  end

  // Final sign correction and half/quotient/remainder selection.
  always_comb begin
    prod       = neg ? -acc : acc;
    div_val    = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    div_signed = neg ? -div_val : div_val;
    if (op[2])              fix_res = div_signed;
    else if (op == MD_MUL)  fix_res = prod[XLEN-1:0];
    else                    fix_res = prod[2*XLEN-1:XLEN];
  end

  // UNROLL iterations chained combinationally per clock.
  assign chain[0] = acc;
  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    mdu_step #(.XLEN(XLEN)) u_step (
      .div_mode (op[2]),
      .acc_in   (chain[g]),
      .opnd     (opnd),
      .acc_out  (chain[g+1])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= MDU_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    unique case (state)
      MDU_IDLE: if (accept) state_nxt = special ? MDU_DONE : MDU_CALC;
      MDU_CALC: if (cnt == '0) state_nxt = MDU_FIX;
      MDU_FIX:  state_nxt = MDU_DONE;
      MDU_DONE: if (out_ready) state_nxt = MDU_IDLE;
      default:  state_nxt = MDU_IDLE;
    endcase
    if (flush) state_nxt = MDU_IDLE;
  end

  // Operand latch, iteration counter, accumulator and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op     <= MD_MUL;
      neg    <= 1'b0;
      result <= '0;
    end else if (accept) begin
      op   <= in_op;
      opnd <= mag_b;
      acc  <= {{XLEN{1'b0}}, mag_a};
      cnt  <= CW'(S - 1);
      // Remainder takes the dividend's sign; product and quotient take sA^sB.
      neg  <= (in_op[2] && in_op[1]) ? sa : (sa ^ sb);
      if (special) result <= special_res;
    end else if (state == MDU_CALC) begin
      acc <= chain[UNROLL];
      if (cnt != '0) cnt <= cnt - 1'b1;
    end else if ((state == MDU_FIX) && !flush) begin
      result <= fix_res;
    end
  end

  assign in_ready  = (state == MDU_IDLE);
  assign out_valid = (state == MDU_DONE);
  assign busy      = (state != MDU_IDLE);

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed cases, back-pressure, flush,
// reset, an UNROLL=2 instance, and randomized ops against a reference model.
module tb_ex_mdu;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_valid2 = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;

  logic        in_ready, out_valid, busy;
  logic [31:0] result;
  logic        in_ready2, out_valid2, busy2;
  logic [31:0] result2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mdu #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .md_op(md_op), .opA(opA), .opB(opB), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  ex_mdu #(.XLEN(32), .UNROLL(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid2), .in_ready(in_ready2),
    .md_op(md_op), .opA(opA), .opB(opB), .out_valid(out_valid2), .out_ready(out_ready),
    .result(result2), .busy(busy2)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: RISC-V M-extension semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sua, sub;
    logic [63:0] p;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    sua = {32'b0, a};
    sub = {32'b0, b};
    case (op)
      3'd0: begin p = sua * sub; return p[31:0];  end
      3'd1: begin p = sa * sb;   return p[63:32]; end
      3'd2: begin p = sa * sub;  return p[63:32]; end
      3'd3: begin p = sua * sub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == MIN_INT && b == 32'hFFFF_FFFF;
  endfunction

  // Issue one op (sel=1 targets the UNROLL=2 instance) and wait for out_valid.
  // k is the index of the edge after which out_valid was first seen (accept edge = 0).
  task automatic run_op(input bit sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int k, output bit stalled);
    @(negedge clk);
    md_op = op; opA = a; opB = b;
    if (sel) in_valid2 = 1'b1; else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid2 = 1'b0;
    md_op = 3'($urandom_range(7)); opA = $urandom; opB = $urandom;
    k = 0; stalled = 1'b1;
    while (!(sel ? out_valid2 : out_valid) && k < 100) begin
      if (sel ? in_ready2 : in_ready) stalled = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    res = sel ? result2 : result;
  endtask

  // Take the result and confirm the unit returns to IDLE with result held.
  task automatic handoff(input bit sel, input string tag, input logic [31:0] res);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " out_valid after handoff"}, sel ? out_valid2 : out_valid, 1'b0);
    check({tag, " in_ready after handoff"}, sel ? in_ready2 : in_ready, 1'b1);
    @(negedge clk); out_ready = 1'b0;
    check({tag, " result held"}, sel ? result2 : result, res);
  endtask

  task automatic do_op(input bit sel, input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int k;
    bit stalled;
    run_op(sel, op, a, b, res, k, stalled);
    check({tag, " result"}, res, exp_res);
    check({tag, " latency"}, k, exp_lat);
    check({tag, " in_ready low while busy"}, stalled, 1'b1);
    handoff(sel, tag, res);
  endtask

  initial begin
    logic [31:0] res, prev, a, b;
    logic [2:0]  op;
    int k;
    bit stalled;

    // Reset values
    #12;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Directed multiplies
    do_op(0, "MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    do_op(0, "MULH min*min", 3'd1, MIN_INT, MIN_INT, 32'h4000_0000, 33);
    do_op(0, "MULHU min*min", 3'd3, MIN_INT, MIN_INT, 32'h4000_0000, 33);
    do_op(0, "MULHSU -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);

    // Directed divides
    do_op(0, "DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op(0, "REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op(0, "DIVU big/2", 3'd5, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 33);

    // Special cases
    do_op(0, "DIV 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    do_op(0, "REMU 5/0", 3'd7, 32'd5, 32'd0, 32'd5, 0);
    do_op(0, "DIV ovf", 3'd4, MIN_INT, 32'hFFFF_FFFF, MIN_INT, 0);
    do_op(0, "REM ovf", 3'd6, MIN_INT, 32'hFFFF_FFFF, 32'h0, 0);

    // Back-pressure: result must stay valid and stable
    run_op(0, 3'd5, 32'd100, 32'd7, res, k, stalled);
    check("bp result", res, 32'd14);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp out_valid held", out_valid, 1'b1);
      check("bp result stable", result, 32'd14);
    end
    handoff(0, "bp", 32'd14);
    prev = 32'd14;

    // flush with in_valid in IDLE must not accept
    @(negedge clk); md_op = 3'd0; opA = 32'd3; opB = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    check("flush+in_valid no accept", busy, 1'b0);
    in_valid = 1'b0; flush = 1'b0;

    // flush in CALC at cycle 5
    @(negedge clk); md_op = 3'd0; opA = 32'd9; opB = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    check("flush out_valid", out_valid, 1'b0);
    check("flush in_ready", in_ready, 1'b1);
    check("flush result dropped", result, prev);
    @(negedge clk); flush = 1'b0;
    // run_op waits only for the next falling edge, so this accepts on the next edge
    do_op(0, "after flush MUL", 3'd0, 32'd12, 32'd11, 32'd132, 33);

    // Reset mid-CALC: outputs return to reset values before any clock edge
    @(negedge clk); md_op = 3'd1; opA = 32'd5; opB = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst mid in_ready", in_ready, 1'b1);
    check("rst mid out_valid", out_valid, 1'b0);
    check("rst mid busy", busy, 1'b0);
    check("rst mid result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // UNROLL=2 instance
    do_op(1, "U2 MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 17);
    do_op(1, "U2 REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 17);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(9))
        0: b = 32'h0;
        1: begin a = MIN_INT; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(15));
        3: a = 32'($urandom_range(255)) - 32'd128;
        default: ;
      endcase
      do_op(i[0], "random", op, a, b, ref_md(op, a, b),
            is_special(op, a, b) ? 0 : (i[0] ? 17 : 33));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
